// File: rtl/seq_detect_if.sv
// seq_detect_if: config, symbol stream and status bundle for seq_detect_ctrl
interface seq_detect_if #(
    parameter int SYM_W   = 3,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
);
    logic                       cfg_we;
    logic [$clog2(PAT_LEN)-1:0] cfg_idx;
    logic [SYM_W-1:0]           cfg_sym;
    logic [$clog2(PAT_LEN):0]   cfg_len;
    logic [CNT_W-1:0]           max_matches;
    logic [TMO_W-1:0]           timeout_cycles;
    logic                       start;
    logic                       stop;
    logic                       sym_valid;
    logic [SYM_W-1:0]           sym_data;
    logic                       sym_ready;
    logic                       sequence_found;
    logic [CNT_W-1:0]           match_count;
    logic                       busy;
    logic                       done;
    logic                       timed_out;

    modport slave (
        input  cfg_we, cfg_idx, cfg_sym, cfg_len, max_matches, timeout_cycles,
        input  start, stop, sym_valid, sym_data,
        output sym_ready, sequence_found, match_count, busy, done, timed_out
    );

    modport master (
        output cfg_we, cfg_idx, cfg_sym, cfg_len, max_matches, timeout_cycles,
        output start, stop, sym_valid, sym_data,
        input  sym_ready, sequence_found, match_count, busy, done, timed_out
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller gating a symbol stream into a pattern-match window
module seq_detect_ctrl #(
    parameter int SYM_W   = 3,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_detect_if.slave io_bus
);
    localparam int LEN_W = $clog2(PAT_LEN) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [SYM_W-1:0] r_pat  [PAT_LEN];
    logic [SYM_W-1:0] r_hist [PAT_LEN];
    logic [SYM_W-1:0] w_hist [PAT_LEN];
    logic [LEN_W-1:0] r_len, r_fill, w_fill, w_len_in;
    logic [CNT_W-1:0] r_max, r_count, w_count;
    logic [TMO_W-1:0] r_tmo, r_timer, w_timer, w_timer_inc;
    logic [PAT_LEN:0] w_eq;
    logic             r_sym_ready, r_found, r_busy, r_done, r_timed_out;
    logic             w_found, w_timed_out, w_match, w_clear, w_accept, w_cfg_open;

    assign w_len_in    = io_bus.cfg_len == '0 ? LEN_W'(1) :
                         (io_bus.cfg_len > LEN_MAX ? LEN_MAX : io_bus.cfg_len);
    assign w_cfg_open  = r_state == S_IDLE || r_state == S_DONE;
    assign w_accept    = r_state == S_RUN && io_bus.sym_valid && r_sym_ready;
    assign w_timer_inc = r_timer + 1'b1;

    // History shift, match detection per possible length, next state and exit priority
    always_comb begin
        w_next      = r_state;
        w_hist      = r_hist;
        w_fill      = r_fill;
        w_count     = r_count;
        w_timer     = r_timer;
        w_found     = 1'b0;
        w_timed_out = r_timed_out;
        w_clear     = 1'b0;
        if (w_accept) begin
            for (int i = PAT_LEN - 1; i > 0; i--) w_hist[i] = r_hist[i-1];
            w_hist[0] = io_bus.sym_data;
            w_fill    = r_fill == LEN_MAX ? r_fill : r_fill + 1'b1;
        end
        w_eq = '0;
        for (int l = 1; l <= PAT_LEN; l++) begin
            w_eq[l] = 1'b1;
            for (int i = 0; i < l; i++) if (w_hist[l-1-i] != r_pat[i]) w_eq[l] = 1'b0;
        end
        w_match = w_accept && w_fill >= r_len && w_eq[r_len];
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next  = io_bus.start ? S_ARM : r_state;
                w_clear = io_bus.start;
            end
            S_ARM: begin
                w_next  = S_RUN;
                w_clear = 1'b1;
            end
            default: begin
                w_found = w_match;
                w_count = w_match ? (&r_count ? r_count : r_count + 1'b1) : r_count;
                w_timer = w_match ? '0 : w_timer_inc;
                if (w_match && r_max != '0 && w_count == r_max) w_next = S_DONE;
                else if (io_bus.stop) w_next = S_DONE;
                else if (!w_match && r_tmo != '0 && w_timer_inc == r_tmo) begin
                    w_next      = S_DONE;
                    w_timed_out = 1'b1;
                end
            end
        endcase
        if (w_clear) begin
            for (int i = 0; i < PAT_LEN; i++) w_hist[i] = '0;
            w_fill      = '0;
            w_count     = '0;
            w_timer     = '0;
            w_timed_out = 1'b0;
        end
    end

    // State, pattern, run registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pat       <= '{default: '0};
            r_hist      <= '{default: '0};
            r_len       <= '0;
            r_fill      <= '0;
            r_max       <= '0;
            r_count     <= '0;
            r_tmo       <= '0;
            r_timer     <= '0;
            r_sym_ready <= 1'b0;
            r_found     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_hist      <= w_hist;
            r_fill      <= w_fill;
            r_count     <= w_count;
            r_timer     <= w_timer;
            r_found     <= w_found;
            r_timed_out <= w_timed_out;
            r_sym_ready <= w_next == S_RUN;
            r_busy      <= w_next == S_ARM || w_next == S_RUN;
            r_done      <= w_next == S_DONE;
            if (w_cfg_open && io_bus.cfg_we) r_pat[io_bus.cfg_idx] <= io_bus.cfg_sym;
            if (w_cfg_open && io_bus.start) begin
                r_len <= w_len_in;
                r_max <= io_bus.max_matches;
                r_tmo <= io_bus.timeout_cycles;
            end
        end
    end

    assign io_bus.sym_ready      = r_sym_ready;
    assign io_bus.sequence_found = r_found;
    assign io_bus.match_count    = r_count;
    assign io_bus.busy           = r_busy;
    assign io_bus.done           = r_done;
    assign io_bus.timed_out      = r_timed_out;
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for 3-bit symbol sequence detection. Holds a programmable pattern of up to PAT_LEN symbols. Gates a valid/ready symbol stream into a match window and pulses sequence_found on every match, overlapping matches included. Counts matches and ends a run on match limit, inactivity timeout or stop, reporting status to the host/test sequencer.

Parameters:
SYM_W, 3, symbol width in bits
PAT_LEN, 4, maximum pattern length in symbols
CNT_W, 8, match counter and match-limit width
TMO_W, 16, timeout counter width

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
cfg_we  input  1  pattern slot write strobe
cfg_idx  input  $clog2(PAT_LEN)  pattern slot index, 0 = oldest symbol
cfg_sym  input  SYM_W  pattern symbol to write
cfg_len  input  $clog2(PAT_LEN)+1  active pattern length, latched at start
max_matches  input  CNT_W  match limit; 0 = unlimited; latched at start
timeout_cycles  input  TMO_W  inactivity limit; 0 = disabled; latched at start
start  input  1  begin run
stop  input  1  abort run
sym_valid  input  1  symbol present
sym_data  input  SYM_W  symbol
sym_ready  output  1  controller accepts symbol
sequence_found  output  1  one-cycle match pulse
match_count  output  CNT_W  matches in current run, saturating
busy  output  1  state is ARM or RUN
done  output  1  run finished, held until next start
timed_out  output  1  run ended by timeout, held with done

Behaviour:
- reset low, asynchronous: state IDLE. All outputs 0. Pattern registers, history, fill counter and timer all cleared.
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE and DONE:
  - sym_ready = 0.
  - cfg_we writes pattern[cfg_idx] = cfg_sym on the clock edge.
  - start moves to ARM and latches cfg_len, max_matches and timeout_cycles.
  - cfg_len = 0 is treated as 1; cfg_len > PAT_LEN is treated as PAT_LEN.
- ARM (exactly 1 cycle): clear history, fill counter, match_count, timer, done and timed_out. Go to RUN.
- ARM and RUN: cfg_we is ignored. start is ignored.
- RUN:
  - sym_ready = 1.
  - On sym_valid & sym_ready, sym_data shifts into the history and fill increments, saturating at PAT_LEN.
  - Match condition: fill >= len, and the last len accepted symbols equal pattern[0..len-1] in order.
  - Overlapping matches count.
  - On a match: sequence_found = 1 for the cycle after the accepting edge; match_count increments, saturating at all-ones; timer clears.
  - Cycles with no match increment the timer, including cycles with no accepted symbol.
  - Exit priority, evaluated per edge:
    1. A match is always counted first.
    2. New match_count == max_matches (max_matches != 0) goes to DONE.
    3. Otherwise stop goes to DONE.
    4. Otherwise timer+1 == timeout_cycles (timeout_cycles != 0, no match this edge) goes to DONE and sets timed_out.
  - Match and timeout on the same edge: the match wins and the timer clears.
  - Match and stop on the same edge: the match is counted, then DONE.
- DONE: done = 1. match_count holds. sequence_found may still show the final match pulse in the first DONE cycle.
- Latency: accept edge to sequence_found high is 1 cycle. start edge to sym_ready high is 2 cycles (ARM, then RUN).
- Reset asserted mid-run returns to IDLE immediately. The pattern is lost and must be rewritten.

Test Plan:
1. Program pattern 001,101,110, len 3, max 0, timeout 0; start; stream 001,101,110 → sequence_found pulses once, 1 cycle after the third accept; match_count = 1; busy = 1.
2. Pattern 110,110, len 2; stream 110,110,110,011 → two pulses, on the 2nd and 3rd accepts; match_count = 2. With max_matches = 2: done = 1 after the 3rd accept and sym_ready drops.
3. Pattern as in 1, timeout_cycles = 5; stream 000 continuously → done = 1 and timed_out = 1 after the 5th RUN cycle; match_count = 0. Repeat with the match completing on the 5th cycle → counted, timer clears, no timeout.
4. Insert sym_valid gaps of 3 cycles between 001, 101 and 110 (len 3, timeout 0) → exactly 1 match. Pulse 1 cycle after the 110 accept.
5. Assert cfg_we to slot 0 with 111 during RUN → pattern unchanged, 001,101,110 still matches. stop → done = 1, timed_out = 0.
6. Drop reset low mid-RUN after 2 matches → same cycle, all outputs 0 and state IDLE. Start again without reprogramming → a stream 000,000,000 against the cleared pattern (000,000,000, len 3) matches on the 3rd accept.
